// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional build macro DM_BE_CHECK_EN (used by dm_responder) restricts legal byte enables.
package dm_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [BE_W-1:0] BE_BYTE1   = 4'b0010;
  localparam logic [BE_W-1:0] BE_BYTE2   = 4'b0100;
  localparam logic [BE_W-1:0] BE_BYTE3   = 4'b1000;
  localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

  // Request fields captured at acceptance.
  typedef struct packed {
    logic              write;
    logic [31:0]       addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } dm_req_t;

  // Expand byte enables to a 32-bit lane mask.
  function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(BE_W); i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  // Naturally aligned byte/half/word patterns; all-zero only for stores.
  function automatic logic be_legal(input logic [BE_W-1:0] be, input logic write);
    logic ok;
    case (be)
      BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
      BE_HALF_LO, BE_HALF_HI, BE_WORD: ok = 1'b1;
      4'b0000:                         ok = write;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-organised storage with per-lane write enables and a registered read port.
module dm_ram
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic [BE_W-1:0]   we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Lane-wise write and registered read; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(BE_W); i++) begin
      if (we_i[i]) begin
        mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, held response.
// Build macro DM_BE_CHECK_EN: reject byte-enable patterns that are not aligned byte/half/word.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [32:0]      LIMIT     = 33'(1) << (ADDR_W + 2);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  dm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dm_req_t           req_q, req_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       off_req_c;
  logic [31:0]       off_cap_c;
  logic              err_c;
  logic [BE_W-1:0]   we_c;
  logic [ADDR_W-1:0] raddr_c;
  logic [DATA_W-1:0] ram_rdata;

  assign req_ready = rst && (state_q == IDLE);
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Address decode; in IDLE the read port follows the live request so data is ready one cycle later.
  always_comb begin
    off_req_c = req_addr - BASE_ADDR;
    off_cap_c = req_q.addr - BASE_ADDR;
    err_c     = (req_q.addr[1:0] != 2'b00) || ({1'b0, off_cap_c} >= LIMIT);
`ifdef DM_BE_CHECK_EN
    err_c     = err_c || !be_legal(req_q.be, req_q.write);
`endif
    raddr_c   = (state_q == IDLE) ? ADDR_W'(off_req_c >> 2) : ADDR_W'(off_cap_c >> 2);
  end

  // Next-state and access control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    we_c    = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.write = req_write;
          req_d.addr  = req_addr;
          req_d.be    = req_be;
          req_d.wdata = req_wdata;
          cnt_d       = WAIT_INIT;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = RESP;
          valid_d = 1'b1;
          err_d   = err_c;
          rdata_d = (err_c || req_q.write) ? '0 : (ram_rdata & be_mask(req_q.be));
          if (!err_c && req_q.write) begin
            we_c = req_q.be;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  dm_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we_c),
    .waddr_i (ADDR_W'(off_cap_c >> 2)),
    .wdata_i (req_q.wdata),
    .raddr_i (raddr_c),
    .rdata_o (ram_rdata)
  );

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the slave end of the CPU load/store interface.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, performs a byte-enabled word read or write on internal storage, and holds the response until the CPU takes it.
- Replaces the zero-latency dm so the multi-cycle control path can be exercised against a slow memory.

Parameters:
- ADDR_W, 10, word-address width; storage depth is 2**ADDR_W 32-bit words (byte range 0 to 4*2**ADDR_W-1).
- WAIT_CYCLES, 1, wait states between acceptance and the access (0 to 15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] must be 0.
- req_be  in  4  byte-lane enables; bit i selects bits [8i+7:8i].
- req_wdata  in  32  store data, lane-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  CPU accepts the response.
- rsp_rdata  out  32  load data; unselected lanes are 0; always 0 for stores and errors.
- rsp_err  out  1  request rejected (misaligned or out of range).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Port names are clk and rst; rst is active-low.
- Reset values (rst low, immediate): state IDLE, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0. Storage is NOT reset. Reset mid-transaction aborts it; a pending write is dropped.
- req_ready is 1 in IDLE only (combinational from state). A request is accepted on an edge where req_valid and req_ready are both 1. write, addr, be and wdata are captured at acceptance; later changes on req_* are ignored.
- States:
  - IDLE: on accept -> WAIT, counter = WAIT_CYCLES.
  - WAIT: if counter != 0, decrement. If counter == 0, perform the access, register rsp_rdata and rsp_err, go to RESP.
  - RESP: rsp_valid = 1; outputs held stable until rsp_ready; on rsp_valid and rsp_ready -> IDLE, rsp_valid drops.
- Latency: for acceptance at edge E, rsp_valid is high after edge E+1+WAIT_CYCLES. The next request can be accepted no earlier than one cycle after the response handshake.
- Address decode: offset = addr - BASE_ADDR (32-bit wrap). Error if addr[1:0] != 0, or offset >= 4*2**ADDR_W. On error: no storage update, rdata 0, rsp_err 1.
- Store: each lane with be[i]=1 takes wdata lane i; other lanes are unchanged. be=0 is a legal no-op.
- Load: rdata lane i = mem lane i if be[i], else 0. A load in the same access slot reads the pre-write contents (only one access per transaction, so no conflict arises).
- rsp_ready high before rsp_valid has no effect.

Optional Feature:
- Macro DM_BE_CHECK_EN.
- Defined: be must be one of 0001, 0010, 0100, 1000, 0011, 1100, 1111 (or 0000 for a store). Any other pattern sets rsp_err, suppresses the write and returns rdata 0.
- Undefined: any be pattern is accepted lane by lane.

Decomposition:
- Package dm_pkg holds:
  - state encoding (IDLE, WAIT, RESP);
  - legal-BE constants (BE_BYTE0..3, BE_HALF_LO, BE_HALF_HI, BE_WORD);
  - a byte-lane mask function, be to 32-bit mask.
- One sub-module, dm_ram: a 2**ADDR_W x 32 synchronous array with a per-lane write enable and a registered read. The responder FSM, counter and decode live in dm_responder.

Test Plan:
- WAIT_CYCLES=2: store addr 0x10, be 1111, data 0xDEADBEEF, then load 0x10 be 1111 -> rdata 0xDEADBEEF, err 0. rsp_valid appears exactly 3 cycles after each accept.
- Partial lanes: store 0x11223344 to 0x20, then store be 0100 data 0x00AA0000 -> load returns 0x11AA3344. Load with be 0011 -> 0x00003344.
- Errors: load addr 0x22 -> err 1, rdata 0. Store addr 4*2**ADDR_W -> err 1, and a following read of word 0 is unchanged.
- Backpressure: hold rsp_ready 0 for 5 cycles -> rsp_valid and rdata stable, req_ready 0 throughout. req_ready returns 1 the cycle after the handshake.
- Reset mid-WAIT: pull rst low during a store's wait -> outputs 0 immediately. After release, the target word still holds its old value.
- DM_BE_CHECK_EN defined: store be 0101 -> err 1, memory unchanged. Undefined: the same store writes lanes 0 and 2, err 0.
